gpio_to_mouse: RTL

GPIO_TO_MOUSE -- requirements
Module: gpio_to_mouse

---
 rtl/gpio_to_mouse_pkg.sv | 17 +
 rtl/gpio_to_mouse_debounce.sv | 99 +++++++++
 rtl/gpio_to_mouse.sv | 38 +++
 3 files changed

// File: rtl/gpio_to_mouse_pkg.sv
// Shared definitions for the GPIO-to-mouse button debouncer.
// Holds the per-channel FSM state encoding and the counter sizing helper.
package gpio_to_mouse_pkg;

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_RISE = 2'd1,
    S_HIGH = 2'd2,
    S_FALL = 2'd3
  } deb_state_t;

  // Counter must hold 0..DEBOUNCE_CYCLES; never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/gpio_to_mouse_debounce.sv
// One button channel: 2-flop synchronizer, then a four-state debounce FSM
// whose level and press/release pulses are registered on the accepting edge.
module gpio_debounce
  import gpio_to_mouse_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 65000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic press,
  output logic rel
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q, s2_q;
  deb_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    case (state_q)
      S_LOW: begin
        if (s2_q) begin
          state_d = S_RISE;
          cnt_d   = '0;
        end
      end
      S_RISE: begin
        if (!s2_q) begin
          state_d = S_LOW;
        end else if (cnt_q == LAST) begin
          state_d = S_HIGH;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HIGH: begin
        if (!s2_q) begin
          state_d = S_FALL;
          cnt_d   = '0;
        end
      end
      S_FALL: begin
        if (s2_q) begin
          state_d = S_HIGH;
        end else if (cnt_q == LAST) begin
          state_d = S_LOW;
          level_d = 1'b0;
          rel_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  // Reset abandons any pending transition, so no pulse can escape it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= S_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      s1_q    <= din;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign level = level_q;
  assign press = press_q;
  assign rel   = rel_q;

endmodule

// File: rtl/gpio_to_mouse.sv
// Debounces two asynchronous remote-board button lines into mouse button
// levels plus one-cycle press/release pulses, one independent channel each.
module gpio_to_mouse
  import gpio_to_mouse_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 65000
) (
  input  logic clk,
  input  logic rst,
  input  logic gpio_left,
  input  logic gpio_right,
  output logic m_left,
  output logic m_right,
  output logic left_press,
  output logic left_release,
  output logic right_press,
  output logic right_release
);

  gpio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left (
    .clk   (clk),
    .rst   (rst),
    .din   (gpio_left),
    .level (m_left),
    .press (left_press),
    .rel   (left_release)
  );

  gpio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (
    .clk   (clk),
    .rst   (rst),
    .din   (gpio_right),
    .level (m_right),
    .press (right_press),
    .rel   (right_release)
  );

endmodule
